can_tx_scheduler: RTL

- Arbitrates CAN transmit requests from NUM_REQ local requesters and sequences the shared frame transmitter.
- Waits for the interframe-detect "ready to transmit" indication before issuing.
- Issues the lowest CAN ID pending (CAN priority), then tracks the outcome.
- Retries lost or errored frames up to a limit; reports per-requester grant or fail pulses.

---
 rtl/can_tx_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: CAN transmit arbiter and frame sequencer.
// Picks the pending request with the lowest CAN identifier (ties go to the
// lowest requester index). It waits for the interframe "ready" indication,
// starts the shared transmitter and then tracks the outcome. Lost or errored
// frames are retried until a per-requester limit is reached.
// Optional feature: define CAN_TXSCHED_WATCHDOG_EN to add a bit-time watchdog.
// When it expires, a stalled transmission is treated as a bus error.
module can_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 11,
    parameter int RETRY_MAX    = 8,
    parameter int TIMEOUT_BITS = 200
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic [NUM_REQ-1:0]         reqValid,
    input  logic [NUM_REQ*ID_W-1:0]    reqId,
    input  logic                       interframePeriod,
    input  logic                       bitPulse,
    input  logic                       txDone,
    input  logic                       txLost,
    input  logic                       txError,
    output logic                       txStart,
    output logic [ID_W-1:0]            txId,
    output logic [$clog2(NUM_REQ)-1:0] txSel,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         fail,
    output logic                       active
);

    localparam int SEL_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUS,
        ISSUE,
        TX,
        RESULT
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [SEL_W-1:0]  r_txSel;
    logic [ID_W-1:0]   r_txId;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_fail;
    logic [3:0]        r_retry [NUM_REQ];

    logic              w_anyReq;
    logic              w_found;
    logic [SEL_W-1:0]  w_selIdx;
    logic [ID_W-1:0]   w_selId;
    logic              w_timeout;
    logic              w_outcome;
    logic              w_success;
    logic [3:0]        w_retryNext;
    logic              w_exhausted;

    assign w_anyReq = |reqValid;

    // Lowest identifier among the currently valid requests; a strict compare keeps the lower index on ties
    always_comb begin
        w_found  = 1'b0;
        w_selIdx = '0;
        w_selId  = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqValid[i] && (!w_found || (reqId[i*ID_W +: ID_W] < w_selId))) begin
                w_found  = 1'b1;
                w_selId  = reqId[i*ID_W +: ID_W];
                w_selIdx = SEL_W'(i);
            end
        end
    end

`ifdef CAN_TXSCHED_WATCHDOG_EN
    localparam int BC_W = $clog2(TIMEOUT_BITS + 1);
    logic [BC_W-1:0] r_bitCnt;

    // Bit-time counter restarted for every frame, advancing on validated bit pulses while on the bus
    always_ff @(posedge clk) begin
        if (!resetN)
            r_bitCnt <= '0;
        else if (r_state == ISSUE)
            r_bitCnt <= '0;
        else if ((r_state == TX) && bitPulse)
            r_bitCnt <= r_bitCnt + BC_W'(1);
    end

    assign w_timeout = (r_state == TX) && (r_bitCnt == BC_W'(TIMEOUT_BITS));
`else
    localparam int unusedTimeoutBits = TIMEOUT_BITS;
    logic w_unusedBitPulse;
    assign w_unusedBitPulse = bitPulse;
    assign w_timeout        = 1'b0;
`endif

    // A real outcome pulse always wins over the watchdog, and error/lost beat done
    assign w_outcome   = txDone | txLost | txError | w_timeout;
    assign w_success   = txDone & ~txLost & ~txError;
    assign w_retryNext = r_retry[r_txSel] + 4'd1;
    assign w_exhausted = (w_retryNext == 4'(RETRY_MAX));

    // State register
    always_ff @(posedge clk) begin
        if (!resetN)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // Next-state sequencing: wait for the bus, issue one start, wait for an outcome, report it
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_anyReq) w_nextState = WAIT_BUS;
            WAIT_BUS: begin
                if (!w_anyReq)
                    w_nextState = IDLE;
                else if (interframePeriod)
                    w_nextState = ISSUE;
            end
            ISSUE:    w_nextState = TX;
            TX:       if (w_outcome) w_nextState = RESULT;
            RESULT:   w_nextState = w_anyReq ? WAIT_BUS : IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    // Latch the winner when the frame is issued and register the one-cycle grant/fail pulses
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_txSel <= '0;
            r_txId  <= '0;
            r_grant <= '0;
            r_fail  <= '0;
        end else begin
            r_grant <= '0;
            r_fail  <= '0;
            if ((r_state == WAIT_BUS) && w_anyReq && interframePeriod) begin
                r_txSel <= w_selIdx;
                r_txId  <= w_selId;
            end
            if ((r_state == TX) && w_outcome) begin
                if (w_success)
                    r_grant <= NUM_REQ'(1) << r_txSel;
                else if (w_exhausted)
                    r_fail  <= NUM_REQ'(1) << r_txSel;
            end
        end
    end

    // Per-requester retry counters; an idle requester always starts again from zero
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!resetN || !reqValid[i])
                r_retry[i] <= 4'd0;
            else if ((r_state == TX) && w_outcome && (r_txSel == SEL_W'(i))) begin
                if (w_success || w_exhausted)
                    r_retry[i] <= 4'd0;
                else
                    r_retry[i] <= w_retryNext;
            end
        end
    end

    assign txStart = (r_state == ISSUE);
    assign active  = (r_state == ISSUE) || (r_state == TX);
    assign txSel   = r_txSel;
    assign txId    = r_txId;
    assign grant   = r_grant;
    assign fail    = r_fail;

endmodule
